ula_nibble_seq: RTL and testbench
=================================

// Module: ula_nibble_seq
// PURPOSE
//  Nibble-serial WIDTH-bit ALU: accepts one operation over a valid/ready request port, runs it
//  through a single internal ula_74181 one nibble per clock (LSB nibble first, carry rippled in a
//  register) and returns result, carry-out and A=B flag over a valid/ready response port.
//  Trades latency for area when a wide datapath must reuse the existing 4-bit 74181 slice.
// PARAMETERS
//  WIDTH    16  operand/result width; multiple of 4, >= 8
//  NIBBLES  WIDTH/4  derived (localparam), nibble steps per operation
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      synchronous, active-low reset
//  req_valid   in   1      request present
//  req_ready   out  1      block can accept a request
//  req_a       in   WIDTH  operand A
//  req_b       in   WIDTH  operand B
//  req_s       in   4      74181 function select
//  req_m       in   1      1 = logic mode, 0 = arithmetic
//  req_c_in    in   1      carry in, ACTIVE-LOW (74181 Cn convention: 0 = carry present)
//  rsp_valid   out  1      result present
//  rsp_ready   in   1      consumer accepts result
//  rsp_f       out  WIDTH  result
//  rsp_c_out   out  1      carry out of top nibble, ACTIVE-LOW (74181 Cn+4 convention)
//  rsp_a_eq_b  out  1      AND of all nibble a_eq_b outputs (1 iff rsp_f == all ones)
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state IDLE, rsp_valid=0, rsp_f=0, rsp_c_out=1, rsp_a_eq_b=0,
//   nibble index 0; reset wins over any handshake in the same cycle, aborts an op in flight, no rsp.
//  req_ready = (state==IDLE), combinational from state only. rsp_valid = (state==DONE).
//  FSM: IDLE --req_valid--> RUN; RUN --idx==NIBBLES-1--> DONE; DONE --rsp_ready--> IDLE.
//  Accept edge (IDLE & req_valid): latch a,b,s,m into op regs; carry_n <= req_c_in; idx <= 0;
//   eq_acc <= 1. Request inputs are ignored outside IDLE.
//  RUN, each cycle: ALU sees a=op_a[4*idx+:4], b=op_b[4*idx+:4], s, m, c_in=carry_n;
//   at the edge: res[4*idx+:4] <= f; carry_n <= c_out; eq_acc <= eq_acc & a_eq_b; idx <= idx+1.
//  Carry ripples identically in logic mode (74181 ignores it); rsp_c_out then reports the 74181
//   top-nibble Cn+4 value unmodified.
//  Latency: accept at edge T -> rsp_valid high after edge T+NIBBLES (WIDTH=16: 4 cycles).
//  DONE: rsp_f/rsp_c_out/rsp_a_eq_b held stable while rsp_valid & !rsp_ready (no drop, no change).
//  Response handshake at edge T2 -> IDLE, req_ready high from T2; next accept no earlier than T2.
//   Throughput: one op per NIBBLES+2 cycles with rsp_ready tied high.
//  rsp_f/rsp_c_out/rsp_a_eq_b are registered; updated only on the RUN->DONE edge (res, carry_n,
//   eq_acc copied); they keep last values in IDLE.
//  idx width $clog2(NIBBLES); never wraps: leaves RUN at NIBBLES-1.
// STRUCTURE
//  Package ula_pkg: NIBBLE_W=4; typedef enum logic [1:0] {IDLE,RUN,DONE} seq_state_t;
//   function-select constants S_ADD=4'b1001, S_SUB=4'b0110, S_XOR=4'b0110 (m=1), S_A=4'b1111, etc.
//  One sub-module: ula_74181 (existing), single instance u_ula, ports a,b,s,m,c_in,f,c_out,a_eq_b.
//  Everything else (FSM, op/result regs, carry reg, index counter) in this module; one always_ff
//   for state/datapath regs, always_comb for nibble mux and handshake outputs.
// TESTING
//  1 Add no carry: s=1001 m=0 c_in=1 a=0x1234 b=0x0FFF -> rsp_f=0x2233, rsp_c_out=1, 4 cycles.
//  2 Add ripple/overflow: s=1001 m=0 c_in=1 a=0xFFFF b=0x0001 -> rsp_f=0x0000, rsp_c_out=0
//    (carry crosses all 4 nibbles via carry_n register).
//  3 Subtract/equality: s=0110 m=0 c_in=0 a=0x1000 b=0x0001 -> 0x0FFF, c_out=0; then
//    s=0110 c_in=1 a=b=0x5A5A -> rsp_f=0xFFFF, rsp_a_eq_b=1; a=0x5A5B -> rsp_a_eq_b=0.
//  4 Logic: m=1 s=0110 a=0xF0F0 b=0xFF00 -> 0x0FF0; m=1 s=1011 a=0xF0F0 b=0xFF00 -> 0xF000.
//  5 Backpressure: rsp_ready=0 for 5 cycles in DONE -> rsp_* stable, req_ready=0, new req_valid
//    ignored; rsp_ready=1 -> IDLE next edge, pending request then accepted.
//  6 Reset mid-op: rst_n=0 at second RUN cycle -> next cycle IDLE, req_ready=1, rsp_valid=0,
//    rsp_f=0; no response ever produced for the aborted op; next op completes normally.
//  Checker: reference model computes nibble-by-nibble 74181 equations; compare on every rsp handshake.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared types and constants for the nibble-serial 74181 ALU sequencer.
package ula_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Common 74181 function selects (active-high data convention)
  localparam logic [3:0] S_ADD = 4'b1001;  // m=0: A plus B
  localparam logic [3:0] S_SUB = 4'b0110;  // m=0: A minus B minus 1 (Cn=1)
  localparam logic [3:0] S_XOR = 4'b0110;  // m=1: A xor B
  localparam logic [3:0] S_AND = 4'b1011;  // m=1: A and B
  localparam logic [3:0] S_OR  = 4'b1110;  // m=1: A or B
  localparam logic [3:0] S_NOT = 4'b0000;  // m=1: not A
  localparam logic [3:0] S_A   = 4'b1111;  // m=1: A

endpackage

// File: rtl/ula_74181.sv
// Combinational 4-bit 74181 ALU slice, active-high data, active-low carries.
module ula_74181
  import ula_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic [3:0]          s,
  input  logic                m,
  input  logic                c_in,
  output logic [NIBBLE_W-1:0] f,
  output logic                c_out,
  output logic                a_eq_b
);

  logic [NIBBLE_W-1:0] x;
  logic [NIBBLE_W-1:0] y;
  logic [NIBBLE_W:0]   carry;

  // Per-bit select terms, internal active-high carry chain and result bits
  always_comb begin
    x     = ~(a | (b & {NIBBLE_W{s[0]}}) | (~b & {NIBBLE_W{s[1]}}));
    y     = ~((a & ~b & {NIBBLE_W{s[2]}}) | (a & b & {NIBBLE_W{s[3]}}));
    carry = '0;
    f     = '0;
    carry[0] = ~c_in;
    for (int i = 0; i < int'(NIBBLE_W); i++) begin
      // Carry chain runs regardless of m; m only masks it from the sum
      carry[i+1] = ~y[i] | (~x[i] & carry[i]);
      f[i]       = x[i] ^ y[i] ^ ~(~m & ~carry[i]);
    end
    c_out  = ~carry[NIBBLE_W];
    a_eq_b = &f;
  end

endmodule

// File: rtl/ula_nibble_seq.sv
// Nibble-serial WIDTH-bit ALU reusing one 74181 slice, valid/ready on both sides.
module ula_nibble_seq
  import ula_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [3:0]       req_s,
  input  logic             req_m,
  input  logic             req_c_in,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_f,
  output logic             rsp_c_out,
  output logic             rsp_a_eq_b
);

  localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
  localparam int unsigned IDX_W   = $clog2(NIBBLES);
  localparam int unsigned BIT_W   = $clog2(WIDTH);

  seq_state_t          state;
  logic [WIDTH-1:0]    op_a;
  logic [WIDTH-1:0]    op_b;
  logic [3:0]          op_s;
  logic                op_m;
  logic                carry_n;
  logic                eq_acc;
  logic [IDX_W-1:0]    idx;
  logic [WIDTH-1:0]    res;

  logic [BIT_W-1:0]    base;
  logic [WIDTH-1:0]    next_res;
  logic                last_nib;
  logic [NIBBLE_W-1:0] alu_a;
  logic [NIBBLE_W-1:0] alu_b;
  logic [NIBBLE_W-1:0] alu_f;
  logic                alu_c_out;
  logic                alu_a_eq_b;

  // Nibble select into the shared slice, merged result and handshake outputs
  always_comb begin
    base      = BIT_W'(32'(idx) * NIBBLE_W);
    alu_a     = op_a[base +: NIBBLE_W];
    alu_b     = op_b[base +: NIBBLE_W];
    next_res  = res;
    next_res[base +: NIBBLE_W] = alu_f;
    last_nib  = (idx == IDX_W'(NIBBLES - 1));
    req_ready = (state == IDLE);
    rsp_valid = (state == DONE);
  end

  ula_74181 u_ula (
    .a      (alu_a),
    .b      (alu_b),
    .s      (op_s),
    .m      (op_m),
    .c_in   (carry_n),
    .f      (alu_f),
    .c_out  (alu_c_out),
    .a_eq_b (alu_a_eq_b)
  );

  // Sequencer state, operand capture, nibble accumulation and response registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_a       <= '0;
      op_b       <= '0;
      op_s       <= '0;
      op_m       <= 1'b0;
      carry_n    <= 1'b1;
      eq_acc     <= 1'b0;
      idx        <= '0;
      res        <= '0;
      rsp_f      <= '0;
      rsp_c_out  <= 1'b1;
      rsp_a_eq_b <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_a    <= req_a;
            op_b    <= req_b;
            op_s    <= req_s;
            op_m    <= req_m;
            carry_n <= req_c_in;
            idx     <= '0;
            eq_acc  <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          res     <= next_res;
          carry_n <= alu_c_out;
          eq_acc  <= eq_acc & alu_a_eq_b;
          if (last_nib) begin
            // Top nibble lands in the response together with the accumulated part
            rsp_f      <= next_res;
            rsp_c_out  <= alu_c_out;
            rsp_a_eq_b <= eq_acc & alu_a_eq_b;
            state      <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_nibble_seq.sv
// Directed self-checking bench for ula_nibble_seq (WIDTH=16).
module tb_ula_nibble_seq;
  import ula_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_s;
  logic        req_m;
  logic        req_c_in;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_f;
  logic        rsp_c_out;
  logic        rsp_a_eq_b;

  int n_cmp;
  int n_bad;

  ula_nibble_seq #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_s      (req_s),
    .req_m      (req_m),
    .req_c_in   (req_c_in),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_f      (rsp_f),
    .rsp_c_out  (rsp_c_out),
    .rsp_a_eq_b (rsp_a_eq_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and wait for its accept edge
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                      input logic m, input logic cin, input string tag);
    req_a = a; req_b = b; req_s = s; req_m = m; req_c_in = cin;
    req_valid = 1'b1;
    check_eq({tag, " req_ready"}, 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  // Wait for rsp_valid, check latency and payload
  task automatic expect_rsp(input logic [15:0] f, input logic c, input logic eq, input string tag);
    int cnt;
    cnt = 0;
    while (!rsp_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    check_eq({tag, " latency"}, 32'(cnt), 32'd4);
    check_eq({tag, " rsp_f"}, 32'(rsp_f), 32'(f));
    check_eq({tag, " rsp_c_out"}, 32'(rsp_c_out), 32'(c));
    check_eq({tag, " rsp_a_eq_b"}, 32'(rsp_a_eq_b), 32'(eq));
  endtask

  // Complete the response handshake and confirm outputs persist in IDLE
  task automatic ack(input logic [15:0] f, input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq({tag, " idle rsp_valid"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, " idle rsp_f held"}, 32'(rsp_f), 32'(f));
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                        input logic m, input logic cin,
                        input logic [15:0] f, input logic c, input logic eq, input string tag);
    send(a, b, s, m, cin, tag);
    expect_rsp(f, c, eq, tag);
    ack(f, tag);
  endtask

  initial begin
    int seen;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_a = '0; req_b = '0; req_s = '0; req_m = 1'b0; req_c_in = 1'b1;
    rsp_ready = 1'b0;
    tick();
    tick();
    check_eq("reset req_ready", 32'(req_ready), 32'd1);
    check_eq("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("reset rsp_f", 32'(rsp_f), 32'd0);
    check_eq("reset rsp_c_out", 32'(rsp_c_out), 32'd1);
    check_eq("reset rsp_a_eq_b", 32'(rsp_a_eq_b), 32'd0);
    rst_n = 1'b1;
    tick();

    // Arithmetic and logic vectors, expected values worked out by hand
    run_op(16'h1234, 16'h0FFF, S_ADD, 1'b0, 1'b1, 16'h2233, 1'b1, 1'b0, "add");
    run_op(16'hFFFF, 16'h0001, S_ADD, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, "add_ovf");
    run_op(16'h1000, 16'h0001, S_SUB, 1'b0, 1'b0, 16'h0FFF, 1'b0, 1'b0, "sub");
    run_op(16'h5A5A, 16'h5A5A, S_SUB, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, "sub_eq");
    run_op(16'h5A5B, 16'h5A5A, S_SUB, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, "sub_ne");
    run_op(16'hF0F0, 16'hFF00, S_XOR, 1'b1, 1'b1, 16'h0FF0, 1'b1, 1'b0, "xor");
    run_op(16'hF0F0, 16'hFF00, S_AND, 1'b1, 1'b1, 16'hF000, 1'b0, 1'b0, "and");
    run_op(16'hFFFF, 16'h1234, S_A,   1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b1, "pass_a");

    // Backpressure: response held while a competing request is ignored
    send(16'h0003, 16'h0004, S_ADD, 1'b0, 1'b1, "bp");
    expect_rsp(16'h0007, 1'b1, 1'b0, "bp");
    req_a = 16'h1111; req_b = 16'h2222; req_s = S_ADD; req_m = 1'b0; req_c_in = 1'b1;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("bp hold rsp_valid", 32'(rsp_valid), 32'd1);
      check_eq("bp hold req_ready", 32'(req_ready), 32'd0);
      check_eq("bp hold rsp_f", 32'(rsp_f), 32'h0007);
      check_eq("bp hold rsp_c_out", 32'(rsp_c_out), 32'd1);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq("bp release rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("bp release req_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check_eq("bp pending accepted", 32'(req_ready), 32'd0);
    expect_rsp(16'h3333, 1'b1, 1'b0, "bp_pending");
    ack(16'h3333, "bp_pending");

    // Reset during the second RUN cycle aborts the op with no response
    send(16'h00FF, 16'h0001, S_ADD, 1'b0, 1'b1, "rst");
    tick();
    rst_n = 1'b0;
    tick();
    check_eq("rst req_ready", 32'(req_ready), 32'd1);
    check_eq("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst rsp_f", 32'(rsp_f), 32'd0);
    check_eq("rst rsp_c_out", 32'(rsp_c_out), 32'd1);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rsp_valid) seen++;
    end
    check_eq("rst no response", 32'(seen), 32'd0);
    run_op(16'h0F0F, 16'h0101, S_ADD, 1'b0, 1'b0, 16'h1011, 1'b1, 1'b0, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
